// File: rtl/intadd_lane_pipe_if.sv
// intadd_lane_pipe_if: beat handshake and lane vectors for intadd_lane_pipe.
// master drives beats and out_ready; slave is the adder pipe.
interface intadd_lane_pipe_if #(
   parameter int DATA_W = 128,
   parameter int LANE_W = 4
);
   logic                       in_valid;
   logic                       in_ready;
   logic [DATA_W-1:0]          src0;
   logic [DATA_W-1:0]          src1;
   logic [DATA_W-1:0]          src2;
   logic                       sign_s0;
   logic                       sign_s2;
   logic                       i_sign_d;
   logic                       acc_en;
   logic                       in_last;
   logic                       out_valid;
   logic                       out_ready;
   logic [DATA_W-1:0]          dst0;
   logic [DATA_W-1:0]          dst1;
   logic [DATA_W/LANE_W-1:0]   sat_flag;

   modport master (
      output in_valid, src0, src1, src2,
      output sign_s0, sign_s2, i_sign_d,
      output acc_en, in_last, out_ready,
      input  in_ready, out_valid,
      input  dst0, dst1, sat_flag
   );

   modport slave (
      input  in_valid, src0, src1, src2,
      input  sign_s0, sign_s2, i_sign_d,
      input  acc_en, in_last, out_ready,
      output in_ready, out_valid,
      output dst0, dst1, sat_flag
   );
endinterface

// File: rtl/intadd_lane_pipe.sv
// intadd_lane_pipe: two-stage lane-wise A + {B_hi,B_lo} adder with accumulate.
// Define INTADD_SAT_EN to clamp results instead of wrapping.
module intadd_lane_pipe #(
   parameter int DATA_W = 128,
   parameter int LANE_W = 4
) (
   input logic               clk,
   input logic               rst_n,
   intadd_lane_pipe_if.slave bus
);
   localparam int N  = DATA_W / LANE_W;
   localparam int RW = 2 * LANE_W;
`ifdef INTADD_SAT_EN
   localparam int SW = RW + 2;
   localparam logic signed [SW-1:0] SMAX = SW'({(RW-1){1'b1}});
   localparam logic signed [SW-1:0] SMIN = ~SMAX;
   localparam logic signed [SW-1:0] UMAX = SW'({RW{1'b1}});
`else
   // Wrap mode only needs the low result bits.
   localparam int SW = RW;
`endif

   logic            adv;
   logic            emit;
   logic            s1_valid;
   logic            s1_sign_d;
   logic            s1_acc;
   logic            s1_last;
   logic [SW-1:0]   in_a [N];
   logic [SW-1:0]   in_b [N];
   logic [SW-1:0]   s1_a [N];
   logic [SW-1:0]   s1_b [N];
   logic [RW-1:0]   acc  [N];
   logic [SW-1:0]   sum  [N];
   logic [RW-1:0]   res  [N];
   logic [N-1:0]    sat;
   logic [DATA_W-1:0] res_lo;
   logic [DATA_W-1:0] res_hi;

   assign adv          = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = adv;
   assign emit         = s1_valid && (!s1_acc || s1_last);

   always_comb begin
      for (int k = 0; k < N; k++) begin
         in_a[k] = bus.sign_s0
            ? SW'($signed(bus.src0[k*LANE_W +: LANE_W]))
            : SW'(bus.src0[k*LANE_W +: LANE_W]);
         in_b[k] = bus.sign_s2
            ? SW'($signed({bus.src2[k*LANE_W +: LANE_W],
                           bus.src1[k*LANE_W +: LANE_W]}))
            : SW'({bus.src2[k*LANE_W +: LANE_W],
                   bus.src1[k*LANE_W +: LANE_W]});
      end
   end

   always_comb begin
      logic [SW-1:0] acc_x;
      acc_x  = '0;
      res_lo = '0;
      res_hi = '0;
      sat    = '0;
      for (int k = 0; k < N; k++) begin
         if (!s1_acc)
            acc_x = '0;
         else if (s1_sign_d)
            acc_x = SW'($signed(acc[k]));
         else
            acc_x = SW'(acc[k]);
         sum[k] = acc_x + s1_a[k] + s1_b[k];
         res[k] = sum[k][RW-1:0];
`ifdef INTADD_SAT_EN
         if (s1_sign_d) begin
            if ($signed(sum[k]) > SMAX) begin
               res[k] = {1'b0, {(RW-1){1'b1}}};
               sat[k] = 1'b1;
            end else if ($signed(sum[k]) < SMIN) begin
               res[k] = {1'b1, {(RW-1){1'b0}}};
               sat[k] = 1'b1;
            end
         end else begin
            if (sum[k][SW-1]) begin
               res[k] = '0;
               sat[k] = 1'b1;
            end else if ($signed(sum[k]) > UMAX) begin
               res[k] = '1;
               sat[k] = 1'b1;
            end
         end
`endif
         res_lo[k*LANE_W +: LANE_W] = res[k][LANE_W-1:0];
         res_hi[k*LANE_W +: LANE_W] = res[k][RW-1:LANE_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid      <= 1'b0;
         s1_sign_d     <= 1'b0;
         s1_acc        <= 1'b0;
         s1_last       <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.dst0      <= '0;
         bus.dst1      <= '0;
         bus.sat_flag  <= '0;
         for (int k = 0; k < N; k++) begin
            s1_a[k] <= '0;
            s1_b[k] <= '0;
            acc[k]  <= '0;
         end
      end else if (adv) begin
         s1_valid  <= bus.in_valid;
         s1_sign_d <= bus.i_sign_d;
         s1_acc    <= bus.acc_en;
         s1_last   <= bus.in_last;
         for (int k = 0; k < N; k++) begin
            s1_a[k] <= in_a[k];
            s1_b[k] <= in_b[k];
         end
         // Non-last accumulate beats only update the partial sums.
         if (s1_valid && s1_acc) begin
            for (int k = 0; k < N; k++)
               acc[k] <= s1_last ? '0 : res[k];
         end
         bus.out_valid <= emit;
         if (emit) begin
            bus.dst0     <= res_lo;
            bus.dst1     <= res_hi;
            bus.sat_flag <= sat;
         end
      end
   end
endmodule

// File: tb/tb_intadd_lane_pipe.sv
// tb_intadd_lane_pipe: directed and random beats against an integer lane model.
// Honours INTADD_SAT_EN the same way as the design.
module tb_intadd_lane_pipe;
   localparam int DATA_W = 128;
   localparam int LANE_W = 4;
   localparam int N      = DATA_W / LANE_W;

   typedef struct {
      logic [DATA_W-1:0] d0;
      logic [DATA_W-1:0] d1;
      logic [N-1:0]      sat;
      int                cyc;
      bit                lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   intadd_lane_pipe_if #(.DATA_W(DATA_W), .LANE_W(LANE_W)) bus ();

   intadd_lane_pipe #(.DATA_W(DATA_W), .LANE_W(LANE_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   n_chk;
   int   n_fail;
   int   cyc;
   int   pops;
   int   n_acc;
   bit   lat_on;
   bit   in_burst;
   exp_t q[$];
   logic [7:0] macc [N];

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] rnd();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic accept();
      exp_t e;
      e.d0  = '0;
      e.d1  = '0;
      e.sat = '0;
      e.cyc = cyc;
      e.lat = lat_on;
      n_acc++;
      for (int k = 0; k < N; k++) begin
         int a, b, s, r;
         bit f;
         a = int'(bus.src0[k*4 +: 4]);
         if (bus.sign_s0 && a >= 8) a -= 16;
         b = int'({bus.src2[k*4 +: 4], bus.src1[k*4 +: 4]});
         if (bus.sign_s2 && b >= 128) b -= 256;
         s = a + b;
         if (bus.acc_en) begin
            r = int'(macc[k]);
            if (bus.i_sign_d && r >= 128) r -= 256;
            s += r;
         end
         r = s;
         f = 1'b0;
`ifdef INTADD_SAT_EN
         if (bus.i_sign_d) begin
            if (s > 127) begin r = 127; f = 1'b1; end
            else if (s < -128) begin r = -128; f = 1'b1; end
         end else begin
            if (s < 0) begin r = 0; f = 1'b1; end
            else if (s > 255) begin r = 255; f = 1'b1; end
         end
`endif
         r = r & 255;
         e.d0[k*4 +: 4] = 4'(r & 15);
         e.d1[k*4 +: 4] = 4'(r >> 4);
         e.sat[k]       = f;
         if (bus.acc_en) macc[k] = bus.in_last ? 8'h00 : 8'(r);
      end
      if (bus.acc_en) in_burst = !bus.in_last;
      if (!bus.acc_en || bus.in_last) q.push_back(e);
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      chk("in_ready", 128'(bus.in_ready),
          128'(!bus.out_valid || bus.out_ready));
      if (bus.out_valid) begin
         if (q.size() == 0) begin
            chk("spurious_out", 128'(bus.out_valid), 128'(0));
         end else begin
            chk("dst0", bus.dst0, q[0].d0);
            chk("dst1", bus.dst1, q[0].d1);
            chk("sat_flag", 128'(bus.sat_flag), 128'(q[0].sat));
            if (q[0].lat) chk("latency", 128'(cyc - q[0].cyc), 128'(2));
            if (bus.out_ready) begin
               void'(q.pop_front());
               pops++;
            end
         end
      end
      if (bus.in_valid && bus.in_ready) accept();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [127:0] v0, v1, v2,
                       input bit s0, s2, sd, ae, last);
      bus.src0     = v0;
      bus.src1     = v1;
      bus.src2     = v2;
      bus.sign_s0  = s0;
      bus.sign_s2  = s2;
      bus.i_sign_d = sd;
      bus.acc_en   = ae;
      bus.in_last  = last;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(input string tag);
      int i = 0;
      while (!bus.out_valid && i < 4) begin
         tick();
         i++;
      end
      chk({tag, "_valid"}, 128'(bus.out_valid), 128'(1));
   endtask

   task automatic gen_beat();
      bus.src0 = rnd();
      bus.src1 = rnd();
      bus.src2 = rnd();
      if (!in_burst) begin
         bus.sign_s0  = $urandom_range(0, 1) == 1;
         bus.sign_s2  = $urandom_range(0, 1) == 1;
         bus.i_sign_d = $urandom_range(0, 1) == 1;
      end
      bus.acc_en  = $urandom_range(0, 1) == 1;
      bus.in_last = $urandom_range(0, 2) == 0;
   endtask

   initial begin
      logic [127:0] v0, v1, v2;
      logic [3:0]   e_d1, e_d0;
      logic         e_sat;
      int           p0, a0, prev, i;

      bus.in_valid  = 1'b0;
      bus.src0      = '0;
      bus.src1      = '0;
      bus.src2      = '0;
      bus.sign_s0   = 1'b0;
      bus.sign_s2   = 1'b0;
      bus.i_sign_d  = 1'b0;
      bus.acc_en    = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      for (int k = 0; k < N; k++) macc[k] = 8'h00;

      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
      chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
      chk("rst_dst0", bus.dst0, 128'(0));
      chk("rst_dst1", bus.dst1, 128'(0));
      chk("rst_sat", 128'(bus.sat_flag), 128'(0));
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // signed underflow: -1 + -128
      lat_on = 1'b1;
      v0 = rnd(); v1 = rnd(); v2 = rnd();
      v0[3:0] = 4'hF; v1[3:0] = 4'h0; v2[3:0] = 4'h8;
`ifdef INTADD_SAT_EN
      e_d1 = 4'h8; e_d0 = 4'h0; e_sat = 1'b1;
`else
      e_d1 = 4'h7; e_d0 = 4'hF; e_sat = 1'b0;
`endif
      send(v0, v1, v2, 1, 1, 1, 0, 0);
      wait_out("sgn_under");
      chk("sgn_under_d1", 128'(bus.dst1[3:0]), 128'(e_d1));
      chk("sgn_under_d0", 128'(bus.dst0[3:0]), 128'(e_d0));
      chk("sgn_under_sat", 128'(bus.sat_flag[0]), 128'(e_sat));

      // unsigned overflow: 15 + 255
      v0 = rnd(); v1 = rnd(); v2 = rnd();
      v0[3:0] = 4'hF; v1[3:0] = 4'hF; v2[3:0] = 4'hF;
`ifdef INTADD_SAT_EN
      e_d1 = 4'hF; e_d0 = 4'hF; e_sat = 1'b1;
`else
      e_d1 = 4'h0; e_d0 = 4'hE; e_sat = 1'b0;
`endif
      send(v0, v1, v2, 0, 0, 0, 0, 0);
      wait_out("uns_over");
      chk("uns_over_d1", 128'(bus.dst1[3:0]), 128'(e_d1));
      chk("uns_over_d0", 128'(bus.dst0[3:0]), 128'(e_d0));
      chk("uns_over_sat", 128'(bus.sat_flag[0]), 128'(e_sat));

      // three-beat accumulate of 1+2 per lane
      repeat (3) tick();
      p0 = pops;
      v0 = {32{4'h1}}; v1 = {32{4'h2}}; v2 = '0;
      send(v0, v1, v2, 0, 0, 0, 1, 0);
      send(v0, v1, v2, 0, 0, 0, 1, 0);
      send(v0, v1, v2, 0, 0, 0, 1, 1);
      wait_out("acc");
      chk("acc_d0", bus.dst0, {32{4'h9}});
      chk("acc_d1", bus.dst1, 128'(0));
      repeat (3) tick();
      chk("acc_pulses", 128'(pops - p0), 128'(1));
      send(v0, v1, v2, 0, 0, 0, 0, 0);
      wait_out("post_acc");
      chk("post_acc_d0", bus.dst0, {32{4'h3}});
      chk("post_acc_d1", bus.dst1, 128'(0));
      repeat (3) tick();

      // reset in the middle of a burst
      send(v0, v1, v2, 0, 0, 0, 1, 0);
      send(v0, v1, v2, 0, 0, 0, 1, 0);
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < N; k++) macc[k] = 8'h00;
      q.delete();
      in_burst = 1'b0;
      chk("mid_rst_valid", 128'(bus.out_valid), 128'(0));
      chk("mid_rst_ready", 128'(bus.in_ready), 128'(1));
      chk("mid_rst_dst0", bus.dst0, 128'(0));
      chk("mid_rst_dst1", bus.dst1, 128'(0));
      chk("mid_rst_sat", 128'(bus.sat_flag), 128'(0));
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      send(v0, v1, v2, 0, 0, 0, 1, 1);
      wait_out("rst_burst");
      chk("rst_burst_d0", bus.dst0, {32{4'h3}});
      chk("rst_burst_d1", bus.dst1, 128'(0));
      repeat (3) tick();

      // eight-beat stream with a five-cycle stall
      lat_on = 1'b0;
      p0 = pops;
      a0 = n_acc;
      i  = 0;
      gen_beat();
      bus.acc_en   = 1'b0;
      bus.in_valid = 1'b1;
      while (n_acc - a0 < 8 && i < 60) begin
         bus.out_ready = !(i >= 3 && i < 8);
         prev = n_acc;
         tick();
         i++;
         if (n_acc != prev) begin
            gen_beat();
            bus.acc_en = 1'b0;
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (4) tick();
      chk("bp_count", 128'(pops - p0), 128'(8));

      // random traffic with bursts and backpressure
      for (int c = 0; c < 400; c++) begin
         gen_beat();
         bus.in_valid  = $urandom_range(0, 3) != 0;
         bus.out_ready = $urandom_range(0, 2) != 0;
         tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      i = 0;
      while (q.size() != 0 && i < 20) begin
         tick();
         i++;
      end
      chk("drain_empty", 128'(q.size()), 128'(0));
      repeat (2) tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/intadd_lane_pipe.md
# intadd_lane_pipe

Pipelined, parametrised lane-wise integer adder for the intadd cell family. It splits DATA_W-bit source vectors into LANE_W-bit lanes and computes per lane src0 + {src2,src1}, with independent operand signedness and a 2·LANE_W result split into low (dst0) and high (dst1) halves. It adds a valid/ready handshake, a fixed two-stage pipeline, and a per-lane accumulate mode for multi-beat reductions. Results can optionally saturate.

## Interface
- DATA_W, 128, vector width; must be a multiple of LANE_W.
- LANE_W, 4, lane width; legal values are 4, 8 and 16. N = DATA_W/LANE_W lanes.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- src0  in  DATA_W  lane addend A (LANE_W per lane).
- src1  in  DATA_W  low half of lane addend B.
- src2  in  DATA_W  high half of lane addend B.
- sign_s0  in  1  A is signed.
- sign_s2  in  1  B ({src2,src1}, 2·LANE_W) is signed.
- i_sign_d  in  1  result is signed; selects the saturation range.
- acc_en  in  1  beat belongs to an accumulate burst.
- in_last  in  1  final beat of an accumulate burst; ignored when acc_en=0.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- dst0  out  DATA_W  low LANE_W bits of each lane result.
- dst1  out  DATA_W  high LANE_W bits of each lane result.
- sat_flag  out  N  lane result was clamped.

## Operation
- Lane k uses bits [k·LANE_W +: LANE_W] of every vector.
- Extension to 2·LANE_W+2 bits:
  - A = sign_s0 ? sext(src0 lane) : zext(src0 lane).
  - B = sign_s2 ? sext({src2,src1}) : zext({src2,src1}).
- Stage S1 registers A, B, the sign controls, acc_en and in_last.
- Stage S2 forms the sum:
  - acc_en=0: sum = A + B. The accumulator is not touched.
  - acc_en=1: sum = acc[k] + A + B. acc[k] is interpreted as signed if i_sign_d=1, otherwise unsigned.
- Result R is sum reduced to 2·LANE_W bits (see Configuration).
- S2 updates:
  - acc_en=0: R is loaded into the output register and out_valid is set.
  - acc_en=1, in_last=0: acc[k] <= R. No output; the beat becomes a bubble.
  - acc_en=1, in_last=1: R is loaded into the output register, out_valid is set, and acc[k] <= 0.
- dst0 lane = R[LANE_W-1:0]; dst1 lane = R[2·LANE_W-1:LANE_W].
- Sign controls are sampled per beat and must be held constant within a burst. Mixing them inside a burst gives an unspecified value but must not corrupt the handshake.
- An acc_en=0 beat arriving mid-burst is processed normally and leaves the accumulator intact.

## Timing
- Global advance signal: adv = !out_valid || out_ready; in_ready = adv.
- All pipeline registers load only when adv=1, so stalls freeze the whole pipe.
- Latency: a beat accepted at edge t produces out_valid at t+2 (after the second edge), unless it is a non-last accumulate beat.
- Throughput is one beat per cycle when out_ready stays high.
- While out_valid=1 && out_ready=0, dst0, dst1 and sat_flag are held stable and in_ready=0.
- Reset (rst_n low, asynchronous):
  - S1/S2 valids, out_valid, dst0, dst1, sat_flag and all acc[k] clear to 0.
  - in_ready reads 1 once out_valid=0.
- Reset mid-burst discards the partial sums. The next burst starts from acc=0.
- A beat leaving the output register and a new result entering it on the same edge is legal; out_valid stays 1.

## Configuration
- INTADD_SAT_EN defined:
  - i_sign_d=1: R is clamped to [-2^(2L-1), 2^(2L-1)-1].
  - i_sign_d=0: R is clamped to [0, 2^(2L)-1].
  - sat_flag[k]=1 when lane k was clamped.
  - The accumulator stores the clamped value.
- INTADD_SAT_EN undefined: R = sum[2L-1:0] (wrap-around) and sat_flag is tied to 0.

## Test plan
All scenarios use LANE_W=4 (8-bit results) and DATA_W=128.
- Signed underflow: lane0 src0=4'hF, {src2,src1}=8'h80, all signs=1, acc_en=0 -> t+2: lane0 dst1=4'h8, dst0=4'h0, sat_flag[0]=1. Without the macro: dst1=4'h7, dst0=4'hF, sat_flag=0.
- Unsigned overflow: src0=4'hF, {src2,src1}=8'hFF, all signs=0 -> dst1=4'hF, dst0=4'hF, sat_flag=1. Without the macro: 8'h0E.
- Accumulate: three beats per lane, src0=1 and {src2,src1}=8'h02, acc_en=1, in_last on beat 3 -> exactly one out_valid pulse carrying dst0=4'h9, dst1=0. A following acc_en=0 beat of 1+2 -> 8'h03.
- Backpressure: stream 8 beats with out_ready low for 5 cycles mid-stream -> in_ready low while out_valid=1, outputs stable, no beat lost or duplicated, order preserved.
- Reset mid-burst: two accumulate beats of 1+2, rst_n pulsed low, then a single last beat of 1+2 -> out_valid within 2 cycles with R=8'h03, and all outputs 0 during reset.
